// File: rtl/tdm_demux4_pkg.sv
// tdm_demux4_pkg: shared TDM geometry and framing-state encoding.
package tdm_demux4_pkg;
    localparam int NCH   = 4;
    localparam int SEL_W = 2;
    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: mod-N slot counter with increment, load-to-1 and clear-to-0.
module tdm_slot_ctr #(
    parameter int N = tdm_demux4_pkg::NCH,
    parameter int W = tdm_demux4_pkg::SEL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         ld1_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb
        cnt_d = clr_i ? '0 :
                ld1_i ? W'(1) :
                inc_i ? (cnt_q == W'(N - 1) ? '0 : cnt_q + W'(1)) : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign cnt_o = cnt_q;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: recovers 4-slot TDM frames from a serial strobe-qualified stream
// with frame_sync lock tracking and a sticky framing-error flag.
module tdm_demux4 #(
    parameter int NCH   = tdm_demux4_pkg::NCH,
    parameter int SEL_W = tdm_demux4_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             frame_sync,
    input  logic             clr_err,
    output logic [NCH-1:0]   q,
    output logic             q_valid,
    output logic [SEL_W-1:0] slot,
    output logic             locked,
    output logic             sync_err
);
    import tdm_demux4_pkg::*;

    state_t           state_q, state_d;
    logic [NCH-1:0]   shadow_q, shadow_d, q_q, q_d;
    logic             q_valid_q, sync_err_q, sync_err_d;
    logic [SEL_W-1:0] slot_w;
    logic             lck, at0, hunt_sync, miss, early, ld1, adv, done;

    assign lck       = state_q == LOCK;
    assign at0       = slot_w == '0;
    assign hunt_sync = en & ~lck & frame_sync;
    assign miss      = en & lck & at0 & ~frame_sync;
    assign early     = en & lck & ~at0 & frame_sync;
    // Any qualified sync starts a fresh frame, whether hunting, wrapping or early.
    assign ld1       = en & frame_sync;
    assign adv       = en & lck & ~at0 & ~frame_sync;
    assign done      = adv & (slot_w == SEL_W'(NCH - 1));

    always_comb begin
        shadow_d = shadow_q;
        if (ld1)      shadow_d[0]      = din;
        else if (adv) shadow_d[slot_w] = din;
    end

    always_comb begin
        state_d    = hunt_sync ? LOCK : miss ? HUNT : state_q;
        q_d        = done ? {din, shadow_q[NCH-2:0]} : q_q;
        sync_err_d = miss | early | (sync_err_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= HUNT;
            shadow_q   <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            q_q        <= q_d;
            q_valid_q  <= done;
            sync_err_q <= sync_err_d;
        end

    tdm_slot_ctr #(.N(NCH), .W(SEL_W)) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (adv),
        .ld1_i (ld1),
        .clr_i (miss),
        .cnt_o (slot_w)
    );

    assign q        = q_q;
    assign q_valid  = q_valid_q;
    assign slot     = slot_w;
    assign locked   = lck;
    assign sync_err = sync_err_q;
endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter NCH, default 4, number of TDM channels/slots per frame; only 4 is supported.
REQ-002 Parameter SEL_W, default 2, slot index width; equals log2(NCH).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  slot strobe; din/frame_sync are sampled only on cycles with en=1.
REQ-006 din  input  1  serial TDM data, one bit per slot (output of a 4:1 mux scanning sel 0..3).
REQ-007 frame_sync  input  1  marks slot 0 of a frame; qualified by en.
REQ-008 clr_err  input  1  clears sticky sync_err.
REQ-009 q  output  NCH  demultiplexed frame; q[k] = bit received in slot k.
REQ-010 q_valid  output  1  one-cycle pulse: q updated with a complete frame.
REQ-011 slot  output  SEL_W  slot index expected at next en strobe.
REQ-012 locked  output  1  1 in LOCK state.
REQ-013 sync_err  output  1  sticky framing-error flag.

Function
REQ-014 FSM states SHALL be HUNT and LOCK only.
REQ-015 HUNT: en=1 and frame_sync=1 -> shadow[0]<=din, slot<=1, go LOCK; all other en cycles ignored, slot held at 0.
REQ-016 LOCK, en=1, slot=k (k=1..3), frame_sync=0 -> shadow[k]<=din, slot<=k+1 mod 4.
REQ-017 LOCK, en=1, slot=3, frame_sync=0 -> q<={din,shadow[2:0]} and q_valid=1 on the following cycle (1-cycle latency from the strobe edge).
REQ-018 LOCK, en=1, slot=0, frame_sync=1 -> shadow[0]<=din, slot<=1 (normal wrap).
REQ-019 LOCK, en=1, slot=0, frame_sync=0 (missing sync) -> sync_err<=1, go HUNT, slot<=0, din discarded.
REQ-020 LOCK, en=1, slot=1..3, frame_sync=1 (early sync) -> sync_err<=1, partial frame discarded, shadow[0]<=din, slot<=1, stay LOCK, no q_valid.
REQ-021 en=0 -> no change to state, slot, shadow, q; q_valid=0.
REQ-022 q SHALL hold its value between q_valid pulses; partial frames never reach q.
REQ-023 q_valid SHALL be 0 on every cycle except the one after a REQ-017 completion.
REQ-024 clr_err=1 clears sync_err on next edge; error event in the same cycle wins (sync_err stays 1).
REQ-025 locked SHALL equal (state==LOCK), registered, no combinational path from inputs.

Reset
REQ-026 rst_n=0 SHALL immediately force state=HUNT, slot=0, shadow=0, q=0, q_valid=0, locked=0, sync_err=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; no q_valid after deassertion until a full new frame completes.
REQ-028 Reset release is synchronous-safe: first sample taken at the first en edge after rst_n=1.

Structure
REQ-029 Shared package SHALL hold NCH, SEL_W and the state encoding (HUNT=0, LOCK=1), also used by the companion 4:1 mux bench.
REQ-030 One sub-module is natural: tdm_slot_ctr (mod-NCH counter with en, load-to-1, clear-to-0); everything else inline.

Verification
REQ-031 Reset, then frames 1000,1010,1011 (q order 3..0) with sync on slot 0, en=1 every cycle -> q=1000,1010,1011, one q_valid per frame, locked=1 after first sync.
REQ-032 en toggling 1/0 each cycle with frame 0011 -> q=0011 after 8 cycles, slot advances only on en=1 cycles.
REQ-033 Locked, drop frame_sync at slot 0 -> sync_err=1, locked=0 next cycle, no q_valid; next sync relocks, frame 1111 -> q=1111.
REQ-034 Locked, frame_sync at slot 2 -> sync_err=1, old q retained, new frame 0100 from that point -> q=0100.
REQ-035 sync_err=1, clr_err=1 in same cycle as new missing sync -> sync_err remains 1; clr_err alone later -> sync_err=0.
REQ-036 rst_n low for 1 cycle after slot 2 of frame 1110 -> all outputs 0 immediately, no q_valid until next full frame 0010 -> q=0010.
